// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store front end for a word-wide data memory. Takes one CPU request at a
// time (byte, halfword or word) and turns it into word accesses:
//   - loads read the word, select the lane and sign/zero-extend it;
//   - word stores write directly;
//   - byte/half stores do a read-modify-write (read in ACCESS, write in MERGE_WR);
//   - misaligned or illegal-size requests get an error response without any
//     memory strobe.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_write, req_size,
//   req_unsigned, req_addr,
//   req_wdata                       request fields, latched on acceptance
//   rsp_valid, rsp_rdata, rsp_err   one-cycle completion pulse with result
//   dm_addr, dm_din, dm_we, dm_re   data-memory word interface (outputs)
//   dm_dout                         combinational read data for dm_addr
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [31:0]       dm_addr,
    output logic [DATA_W-1:0] dm_din,
    output logic              dm_we,
    output logic              dm_re,
    input  logic [DATA_W-1:0] dm_dout
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MERGE_WR = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t              state_reg, state_next;

    logic [ADDR_W-1:0]   addr_reg;
    logic [1:0]          size_reg;
    logic                write_reg;
    logic                unsigned_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   merge_reg;

    logic                rsp_valid_reg;
    logic                rsp_err_reg;
    logic [DATA_W-1:0]   rsp_rdata_reg;

    logic                accept;
    logic                req_legal;
    logic [DATA_W-1:0]   byte_shift;
    logic [DATA_W-1:0]   half_shift;
    logic [DATA_W-1:0]   load_val;
    logic [DATA_W-1:0]   merge_val;

    assign req_ready = (state_reg == IDLE);
    assign accept    = req_valid && req_ready;

    // Halves must be 2-byte aligned, words 4-byte aligned, size 11 never legal.
    always_comb begin
        req_legal = 1'b1;
        case (req_size)
            SIZE_HALF: req_legal = ~req_addr[0];
            SIZE_WORD: req_legal = (req_addr[1:0] == 2'b00);
            SIZE_BYTE: req_legal = 1'b1;
            default:   req_legal = 1'b0;
        endcase
    end

    // Word index; dm_addr follows the latched address in every state.
    assign dm_addr = 32'(addr_reg[ADDR_W-1:2]);

    // Little-endian lane selection: shift the addressed lane down to bit 0.
    assign byte_shift = dm_dout >> {addr_reg[1:0], 3'b000};
    assign half_shift = dm_dout >> {addr_reg[1], 4'b0000};

    always_comb begin
        load_val = dm_dout;
        case (size_reg)
            SIZE_BYTE: load_val = unsigned_reg ? {24'd0, byte_shift[7:0]}
                                               : {{24{byte_shift[7]}}, byte_shift[7:0]};
            SIZE_HALF: load_val = unsigned_reg ? {16'd0, half_shift[15:0]}
                                               : {{16{half_shift[15]}}, half_shift[15:0]};
            default:   load_val = dm_dout;
        endcase
    end

    // Read-modify-write: replace only the addressed lane of the current word.
    always_comb begin
        merge_val = dm_dout;
        case (size_reg)
            SIZE_BYTE: merge_val[{addr_reg[1:0], 3'b000} +: 8]  = wdata_reg[7:0];
            SIZE_HALF: merge_val[{addr_reg[1], 4'b0000} +: 16]  = wdata_reg[15:0];
            default:   merge_val = dm_dout;
        endcase
    end

    // Next state and memory strobes, decoded from state only so that an
    // asynchronous reset drops dm_we/dm_re immediately.
    always_comb begin
        state_next = state_reg;
        dm_re      = 1'b0;
        dm_we      = 1'b0;
        dm_din     = '0;
        case (state_reg)
            IDLE: begin
                if (accept && req_legal) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (write_reg && (size_reg == SIZE_WORD)) begin
                    dm_we      = 1'b1;
                    dm_din     = wdata_reg;
                    state_next = IDLE;
                end else if (write_reg) begin
                    dm_re      = 1'b1;
                    state_next = MERGE_WR;
                end else begin
                    dm_re      = 1'b1;
                    state_next = IDLE;
                end
            end
            MERGE_WR: begin
                dm_we      = 1'b1;
                dm_din     = merge_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            size_reg      <= '0;
            write_reg     <= 1'b0;
            unsigned_reg  <= 1'b0;
            wdata_reg     <= '0;
            merge_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            // Response flags are single-cycle pulses; rdata holds until the
            // next response.
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg     <= req_addr;
                        size_reg     <= req_size;
                        write_reg    <= req_write;
                        unsigned_reg <= req_unsigned;
                        wdata_reg    <= req_wdata;
                        if (!req_legal) begin
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                            rsp_rdata_reg <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (!write_reg) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_rdata_reg <= load_val;
                    end else if (size_reg == SIZE_WORD) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_rdata_reg <= '0;
                    end else begin
                        merge_reg <= merge_val;
                    end
                end
                MERGE_WR: begin
                    rsp_valid_reg <= 1'b1;
                    rsp_rdata_reg <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end directly upstream of the word-wide data memory. It accepts one CPU memory request at a time, with byte, halfword or word size. It converts each request into data-memory word accesses: sub-word stores become a read-modify-write, and load data is returned extended and lane-shifted. Misaligned and illegal-size requests are rejected without touching memory.

## Interface
- ADDR_W, 32, byte-address width of req_addr.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; equals (state==IDLE).
- req_write  input  1  1=store, 0=load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend; ignored for word and stores.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  one-cycle completion pulse, loads and stores.
- rsp_rdata  output  32  load result, valid with rsp_valid; 0 for stores and errors.
- rsp_err  output  1  with rsp_valid: misaligned or illegal size.
- dm_addr  output  32  word index = {2'b00, addr_q[31:2]}.
- dm_din  output  32  write data to memory; 0 when dm_we=0.
- dm_we  output  1  memory write enable, sampled by memory at posedge.
- dm_re  output  1  memory read strobe.
- dm_dout  input  32  combinational read data for dm_addr.

## Operation
- Acceptance: req_valid && req_ready at a posedge. All req_* fields are latched into addr_q, size_q, etc. Later changes are ignored.
- States: IDLE, ACCESS, MERGE_WR.
- IDLE:
  - On acceptance of a legal request, go to ACCESS.
  - On acceptance of an illegal request, stay in IDLE and pulse rsp_valid=1, rsp_err=1 next cycle. No dm_re and no dm_we.
  - Illegal requests: size 11; half with addr[0]=1; word with addr[1:0]!=0.
- ACCESS:
  - Load: dm_re=1. Extract the lane and extend, register the result into rsp_rdata, set rsp_valid, go to IDLE.
  - Word store: dm_we=1, dm_din=wdata_q. Set rsp_valid, go to IDLE.
  - Byte/half store: dm_re=1. Register merge = dm_dout with the target lane replaced by wdata_q low bits. Go to MERGE_WR.
- MERGE_WR: dm_we=1, dm_din=merge. Set rsp_valid, go to IDLE.
- Lanes are little-endian:
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half h = addr[1] occupies bits [16h+15:16h].
- Sign-extension uses bit 7 (byte) or bit 15 (half) of the selected lane.
- dm_addr is driven from addr_q in every state; it holds its last value in IDLE.
- dm_re and dm_we are decoded combinationally from state and never both 1.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, dm_we=0, dm_re=0, dm_din=0, dm_addr=0, all latches 0.
- Latency from acceptance edge N:
  - Load: ACCESS in cycle N+1, rsp_valid in cycle N+2.
  - Word store: write occurs at edge N+2, rsp_valid in cycle N+2.
  - Sub-word store: read in N+1, write in N+2 (committed at edge N+3), rsp_valid in cycle N+3.
  - Error: rsp_valid in cycle N+1.
- rsp_valid is exactly one cycle wide. Other responses clear to 0 in the following cycle, except rsp_rdata, which holds until the next response.
- A new request can be accepted in the same cycle rsp_valid is high, because the state is IDLE. This gives back-to-back throughput of one load every 2 cycles.
- Reset mid-operation: dm_we and dm_re drop asynchronously. A pending MERGE_WR write is abandoned and memory is unchanged. No rsp_valid is issued for the abandoned request.
- Address bits above the memory depth alias inside the memory. This unit performs no range check.

## Test plan
- Word round trip: store 0xDEADBEEF @0x08, then load word @0x08. Required: dm_addr=2, rsp_rdata=0xDEADBEEF; store rsp_valid at N+2, load rsp_valid at N+2.
- Byte RMW: word @0x04=0x11223344, store byte 0xAB @0x06. Required: memory word =0x11AB3344, dm_re at N+1, dm_we at N+2, rsp_valid at N+3.
- Extension: word @0x0C=0x80F0017F.
  - lb @0x0C → 0x0000007F.
  - lb @0x0F → 0xFFFFFF80.
  - lbu @0x0F → 0x00000080.
  - lh @0x0E → 0xFFFF80F0.
  - lhu @0x0E → 0x000080F0.
- Misalign: lw @0x02, sh @0x05, size=11. Each required: rsp_valid=1 and rsp_err=1 at N+1, dm_we and dm_re never asserted, memory unchanged.
- Back-to-back: req_valid held high with 4 loads. Required: accepted on every second edge, rsp_valid pulses 2 cycles apart, req_ready low only in ACCESS.
- Reset in MERGE_WR: assert rst_n=0 mid-cycle during a byte store. Required: dm_we falls immediately, target word retains its old value, all outputs at reset values, req_ready=1.
